systolic_input_feeder: RTL and testbench

//  Upstream stage of the 4x4 weight-stationary systolic array. Loads one weight tile row by row.

---
 rtl/systolic_pkg.sv | 26 ++
 rtl/systolic_input_feeder_skew_delay_line.sv | 34 +++
 rtl/systolic_input_feeder.sv | 135 +++++++++++++
 tb/tb_systolic_input_feeder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath: default geometry,
// the feeder state encoding and the drain length used by the feeder,
// the array and the ofmap collector.
package systolic_pkg;

  localparam int P_IFMAP_WIDTH  = 16;
  localparam int P_WEIGHT_WIDTH = 16;
  localparam int P_ARRAY_HEIGHT = 4;
  localparam int P_ARRAY_WIDTH  = 4;

  // Beats needed for the last ifmap element to ripple through the skew
  // and across the array so every partial sum reaches the bottom row.
  function automatic int drain_beats(input int height, input int width);
    return height + width - 1;
  endfunction

  localparam int DRAIN_BEATS = drain_beats(P_ARRAY_HEIGHT, P_ARRAY_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/systolic_input_feeder_skew_delay_line.sv
// Beat-enabled delay line for one ifmap lane. DEPTH=0 is a plain wire so
// lane 0 reaches the array with no extra skew.
module skew_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused_ctl;
    assign w_unused_ctl = ^{i_clk, i_rst_n, i_en};
    assign o_q = i_d;
  end else begin : g_taps
    logic [WIDTH-1:0] r_taps [DEPTH];

    // Shift one position per beat; stalls hold every tap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int k = 0; k < DEPTH; k++) r_taps[k] <= '0;
      end else if (i_en) begin
        r_taps[0] <= i_d;
        for (int k = 1; k < DEPTH; k++) r_taps[k] <= r_taps[k-1];
      end
    end

    assign o_q = r_taps[DEPTH-1];
  end

endmodule

// File: rtl/systolic_input_feeder.sv
// Feeds one tile into the weight-stationary array: loads the weight rows,
// streams ifmap vectors with per-lane diagonal skew, then drains with zeros.
//
//   state  | meaning
//   IDLE   | waiting for start; no handshakes, array held
//   LOAD_W | accepting ARRAY_HEIGHT weight rows, one we pulse per row
//   STREAM | accepting ifmap vectors, one beat per accepted vector
//   DRAIN  | DRAIN_BEATS back-to-back zero beats, done on exit
module systolic_input_feeder
  import systolic_pkg::*;
#(
  parameter int IFMAP_WIDTH  = P_IFMAP_WIDTH,
  parameter int WEIGHT_WIDTH = P_WEIGHT_WIDTH,
  parameter int ARRAY_HEIGHT = P_ARRAY_HEIGHT,
  parameter int ARRAY_WIDTH  = P_ARRAY_WIDTH
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_start,
  input  logic                                i_weight_valid,
  output logic                                o_weight_ready,
  input  logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0] i_weight_data,
  input  logic                                i_ifmap_valid,
  output logic                                o_ifmap_ready,
  input  logic [ARRAY_HEIGHT*IFMAP_WIDTH-1:0] i_ifmap_data,
  input  logic                                i_ifmap_last,
  output logic                                o_array_enable,
  output logic                                o_array_weight_we,
  output logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0] o_array_weight_in,
  output logic [ARRAY_HEIGHT*IFMAP_WIDTH-1:0] o_array_ifmap_in,
  output logic                                o_busy,
  output logic                                o_done
);

  localparam int LANES_W   = ARRAY_HEIGHT * IFMAP_WIDTH;
  localparam int DRAIN_LEN = drain_beats(ARRAY_HEIGHT, ARRAY_WIDTH);
  localparam int ROW_CW    = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
  localparam int DRN_CW    = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
  localparam logic [ROW_CW-1:0] ROW_LAST = ROW_CW'(ARRAY_HEIGHT - 1);
  localparam logic [DRN_CW-1:0] DRN_LAST = DRN_CW'(DRAIN_LEN - 1);

  feeder_state_t r_state, w_state_nxt;
  logic [ROW_CW-1:0] r_row;
  logic [DRN_CW-1:0] r_drain;

  logic w_w_accept, w_beat, w_zero_fill, w_drain_end;
  logic [LANES_W-1:0] w_lane_in, w_skew_q;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, handshake readies and beat qualification.
  always_comb begin
    w_state_nxt    = r_state;
    o_weight_ready = 1'b0;
    o_ifmap_ready  = 1'b0;
    w_w_accept     = 1'b0;
    w_beat         = 1'b0;
    w_zero_fill    = 1'b0;
    w_drain_end    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = LOAD_W;
      end
      LOAD_W: begin
        o_weight_ready = 1'b1;
        w_w_accept     = i_weight_valid;
        if (i_weight_valid && (r_row == ROW_LAST)) w_state_nxt = STREAM;
      end
      STREAM: begin
        o_ifmap_ready = 1'b1;
        w_beat        = i_ifmap_valid;
        if (i_ifmap_valid && i_ifmap_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_beat      = 1'b1;
        w_zero_fill = 1'b1;
        if (r_drain == DRN_LAST) begin
          w_drain_end = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Weight row and drain beat counters, both wrapping to 0 when their phase ends.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row   <= '0;
      r_drain <= '0;
    end else begin
      if (w_w_accept) r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      if (r_state == DRAIN) r_drain <= w_drain_end ? '0 : r_drain + 1'b1;
    end
  end

  assign w_lane_in = w_zero_fill ? '0 : i_ifmap_data;

  for (genvar i = 0; i < ARRAY_HEIGHT; i++) begin : g_lane
    skew_delay_line #(
      .WIDTH (IFMAP_WIDTH),
      .DEPTH (i)
    ) u_skew (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (w_beat),
      .i_d     (w_lane_in[i*IFMAP_WIDTH +: IFMAP_WIDTH]),
      .o_q     (w_skew_q[i*IFMAP_WIDTH +: IFMAP_WIDTH])
    );
  end

  // Registered array-side outputs; the ifmap register advances only on beats.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_array_enable    <= 1'b0;
      o_array_weight_we <= 1'b0;
      o_array_weight_in <= '0;
      o_array_ifmap_in  <= '0;
      o_done            <= 1'b0;
    end else begin
      o_array_enable    <= w_beat;
      o_array_weight_we <= w_w_accept;
      o_done            <= w_drain_end;
      if (w_w_accept) o_array_weight_in <= i_weight_data;
      if (w_beat)     o_array_ifmap_in  <= w_skew_q;
    end
  end

  assign o_busy = (r_state != IDLE);

endmodule

// File: tb/tb_systolic_input_feeder.sv
module tb_systolic_input_feeder;

  localparam int LW = 16;
  localparam int H  = 4;
  localparam int DR = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        wv = 1'b0;
  logic        iv = 1'b0;
  logic        il = 1'b0;
  logic [63:0] wd = '0;
  logic [63:0] id = '0;

  logic        w_ready, i_ready, arr_en, arr_we, busy, done;
  logic [63:0] arr_w, arr_i;

  systolic_input_feeder dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_start           (start),
    .i_weight_valid    (wv),
    .o_weight_ready    (w_ready),
    .i_weight_data     (wd),
    .i_ifmap_valid     (iv),
    .o_ifmap_ready     (i_ready),
    .i_ifmap_data      (id),
    .i_ifmap_last      (il),
    .o_array_enable    (arr_en),
    .o_array_weight_we (arr_we),
    .o_array_weight_in (arr_w),
    .o_array_ifmap_in  (arr_i),
    .o_busy            (busy),
    .o_done            (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        wq[$];
  exp_t        iq[$];
  exp_t        dq[$];
  logic [63:0] hist[$];

  int   checks = 0;
  int   failures = 0;
  bit   sb_en = 1'b0;
  int   en_cnt = 0;
  exp_t me;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic note_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s got=event expected=none", nm);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Lane i of beat b carries lane i of the vector issued i beats earlier.
  function automatic logic [63:0] skew_out(input int b);
    logic [63:0] r;
    logic [63:0] v;
    r = '0;
    for (int i = 0; i < H; i++) begin
      if (b >= i) begin
        v = hist[b-i];
        r[i*LW +: LW] = v[i*LW +: LW];
      end
    end
    return r;
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && sb_en) begin
      if (arr_we === 1'b1) begin
        if (wq.size() == 0) note_fail("weight_we_unexpected");
        else begin
          me = wq.pop_front();
          chk("weight_row", arr_w, me.data);
          chk("weight_we_cycle", 64'(cyc), 64'(me.cyc));
        end
      end
      if (arr_en === 1'b1) begin
        en_cnt++;
        if (iq.size() == 0) note_fail("enable_unexpected");
        else begin
          me = iq.pop_front();
          chk("ifmap_beat", arr_i, me.data);
          chk("enable_cycle", 64'(cyc), 64'(me.cyc));
        end
      end
      if (done === 1'b1) begin
        if (dq.size() == 0) note_fail("done_unexpected");
        else begin
          me = dq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(me.cyc));
          chk("tile_enable_count", 64'(en_cnt), me.data);
        end
        en_cnt = 0;
      end
    end
  end

  task automatic send_weight(input logic [63:0] d, input bit gap, input bit rnd_start);
    int   n;
    bit   acc;
    exp_t e;
    n = 0;
    if (gap) begin
      wv = 1'b0; wd = rnd64();
      @(posedge clk); #1;
    end
    wv = 1'b1; wd = d;
    forever begin
      if (rnd_start) start = 1'($urandom_range(0, 1));
      acc = w_ready;
      if (acc) begin
        e.data = d; e.cyc = cyc + 1;
        wq.push_back(e);
      end
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 40) begin note_fail("weight_accept_timeout"); break; end
    end
    wv = 1'b0;
  endtask

  task automatic send_vec(input logic [63:0] d, input bit last, input int gap,
                          input bit rnd_start, output int acc_cyc);
    int   n;
    bit   acc;
    exp_t e;
    n = 0;
    acc_cyc = cyc;
    for (int g = 0; g < gap; g++) begin
      iv = 1'b0; id = rnd64(); il = 1'($urandom_range(0, 1));
      if (rnd_start) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    iv = 1'b1; id = d; il = last;
    forever begin
      if (rnd_start) start = 1'($urandom_range(0, 1));
      acc = i_ready;
      if (acc) begin
        hist.push_back(d);
        e.data = skew_out(hist.size() - 1); e.cyc = cyc + 1;
        iq.push_back(e);
        acc_cyc = cyc + 1;
      end
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 40) begin note_fail("ifmap_accept_timeout"); break; end
    end
    iv = 1'b0; il = 1'b0;
  endtask

  // mode: 0 = valid always high (one weight gap), 1 = alternate stalls, 2 = random stalls
  task automatic run_tile(input int nvec, input int mode, input bit hold_start,
                          input bit chained, input bit pulse_start, input bit directed);
    int          lastc;
    int          gap;
    int          n;
    logic [63:0] d;
    exp_t        e;
    if (chained) begin
      @(posedge clk); #1;
      chk("chain_busy", 64'(busy), 64'd1);
      chk("chain_weight_ready", 64'(w_ready), 64'd1);
      start = 1'b0;
    end else begin
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold_start) start = 1'b0;
      chk("start_busy", 64'(busy), 64'd1);
    end
    hist.delete();
    for (int r = 0; r < H; r++) begin
      d = directed ? {4{16'(r + 1)}} : rnd64();
      send_weight(d, (mode == 0) ? (r == 2) : 1'($urandom_range(0, 1)), pulse_start && !hold_start);
    end
    lastc = cyc;
    for (int k = 0; k < nvec; k++) begin
      if (directed) for (int i = 0; i < H; i++) d[i*LW +: LW] = 16'(10 * k + i + 1);
      else d = rnd64();
      if (mode == 0)      gap = 0;
      else if (mode == 1) gap = (k > 0) ? 1 : 0;
      else                gap = $urandom_range(0, 2);
      send_vec(d, k == nvec - 1, gap, pulse_start && !hold_start, lastc);
    end
    start = hold_start;
    for (int j = 1; j <= DR; j++) begin
      hist.push_back('0);
      e.data = skew_out(hist.size() - 1); e.cyc = lastc + j;
      iq.push_back(e);
    end
    e.data = 64'(nvec + DR); e.cyc = lastc + DR;
    dq.push_back(e);
    n = 0;
    while (cyc < lastc + DR && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_pulse", 64'(done), 64'd1);
    chk("idle_after_drain", 64'(busy), 64'd0);
  endtask

  initial begin
    int lc;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_enable", 64'(arr_en), 64'd0);
    chk("reset_we", 64'(arr_we), 64'd0);
    chk("reset_ifmap", arr_i, 64'd0);
    rst_n = 1'b1;

    // Reset mid-STREAM after two beats.
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int r = 0; r < H; r++) send_weight(rnd64(), 1'b0, 1'b0);
    send_vec(rnd64() | 64'h1, 1'b0, 0, 1'b0, lc);
    send_vec(rnd64() | 64'h1, 1'b0, 0, 1'b0, lc);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_enable", 64'(arr_en), 64'd0);
    chk("midrst_we", 64'(arr_we), 64'd0);
    chk("midrst_weight_in", arr_w, 64'd0);
    chk("midrst_ifmap_in", arr_i, 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ifmap_ready", 64'(i_ready), 64'd0);
    chk("midrst_weight_ready", 64'(w_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wq.delete(); iq.delete(); dq.delete(); hist.delete();
    wv = 1'b1; wd = rnd64(); iv = 1'b1; id = rnd64();
    repeat (5) begin
      @(posedge clk); #1;
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_we", 64'(arr_we), 64'd0);
      chk("post_rst_enable", 64'(arr_en), 64'd0);
    end
    wv = 1'b0; iv = 1'b0;
    sb_en = 1'b1;

    run_tile(3, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_tile(3, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_tile(1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_tile(4, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    run_tile(3, 2, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int t = 0; t < 5; t++) run_tile($urandom_range(1, 6), 2, 1'b0, 1'b0, 1'b1, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("weight_queue_empty", 64'(wq.size()), 64'd0);
    chk("ifmap_queue_empty", 64'(iq.size()), 64'd0);
    chk("done_queue_empty", 64'(dq.size()), 64'd0);
    chk("final_idle", 64'(busy), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
